// File: rtl/wb_regfile.sv
// wb_regfile: NREG x DSIZE register file with R0 hardwired to zero, two combinational read ports
// Optional same-cycle write-through bypass when WB_REGFILE_BYPASS_EN is defined
module wb_regfile #(
    parameter int DSIZE = 16,
    parameter int ASIZE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wen,
    input  logic [ASIZE-1:0] waddr,
    input  logic [DSIZE-1:0] wdata,
    input  logic [ASIZE-1:0] raddr1,
    input  logic [ASIZE-1:0] raddr2,
    output logic [DSIZE-1:0] rdata1,
    output logic [DSIZE-1:0] rdata2
);
    localparam int NREG = 1 << ASIZE;

    logic [DSIZE-1:0] regs [NREG];
    logic             wr_ok;

    assign wr_ok = wen && (waddr != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else if (wr_ok) begin
            regs[waddr] <= wdata;
        end
    end

    always_comb begin
`ifdef WB_REGFILE_BYPASS_EN
        rdata1 = (rst || raddr1 == '0) ? '0 : (wr_ok && raddr1 == waddr) ? wdata : regs[raddr1];
        rdata2 = (rst || raddr2 == '0) ? '0 : (wr_ok && raddr2 == waddr) ? wdata : regs[raddr2];
`else
        rdata1 = (rst || raddr1 == '0) ? '0 : regs[raddr1];
        rdata2 = (rst || raddr2 == '0) ? '0 : regs[raddr2];
`endif
    end
endmodule
